grid_scanner: RTL
=================

GRID_SCANNER -- requirements
Module: grid_scanner

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 4, meaning the number of 16-bit rows buffered before the scan stalls (power of 2, 2..16).
REQ-002 clk  input  1  the single clock; all state SHALL change on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  one-cycle request to begin a 16x16 scan.
REQ-005 pos_x  output  4  current column, driven to the circle-membership stage's position_x.
REQ-006 pos_y  output  4  current row, driven to the circle-membership stage's position_y.
REQ-007 activated  input  1  combinational membership result for (pos_x, pos_y), valid in the same cycle.
REQ-008 row_data  output  16  FIFO head row bitmap; bit k = activated at pos_x=k.
REQ-009 row_idx  output  4  pos_y of the row in row_data.
REQ-010 row_valid  output  1  row_data/row_idx hold a valid row.
REQ-011 row_ready  input  1  consumer accepts the row.
REQ-012 count  output  9  total activated points of the current/last scan (0..256).
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  1  one-cycle pulse at scan completion.

Function
REQ-015 The FSM SHALL have states IDLE, SCAN, DRAIN, DONE.
REQ-016 In IDLE, start=1 SHALL move to SCAN next cycle with pos_x=0, pos_y=0, count=0, row shift register cleared; start SHALL be ignored in other states.
REQ-017 In SCAN, each non-stalled cycle SHALL sample activated into bit pos_x of the row register, add it to count, and advance pos_x; pos_x wraps 15->0 with pos_y incrementing.
REQ-018 When sampling at pos_x=15, the completed row {pos_y, 16-bit bitmap including this sample} SHALL be pushed into the FIFO in that same cycle.
REQ-019 Stall: if pos_x=15 and the FIFO is full (registered flag), the cycle SHALL have no effect (no sample, no count, no advance); the stall persists until not full.
REQ-020 A pop in the same cycle as a full FIFO SHALL NOT permit a push that cycle (no bypass); push plus pop when not full SHALL leave occupancy unchanged.
REQ-021 After pushing row 15, the FSM SHALL enter DRAIN; pos_x, pos_y SHALL return to 0.
REQ-022 DRAIN SHALL move to DONE in the cycle after the FIFO is observed empty; DONE SHALL assert done for exactly one cycle and return to IDLE.
REQ-023 row_valid SHALL equal FIFO not empty; a pop SHALL occur when row_valid and row_ready are both high; rows SHALL be delivered in idx order 0..15.
REQ-024 row_data/row_idx SHALL stay stable while row_valid=1 and row_ready=0.
REQ-025 count SHALL hold its final value in IDLE until the next accepted start; it SHALL never wrap (max 256 fits 9 bits).
REQ-026 With no stalls, the scan SHALL take exactly 256 SCAN cycles; the first row SHALL be valid in the cycle after the 16th SCAN cycle.

Reset
REQ-027 rst=1 SHALL, asynchronously: state=IDLE, FIFO empty, pos_x=0, pos_y=0, row register=0, count=0, row_valid=0, row_data=0, row_idx=0, busy=0, done=0.
REQ-028 Reset mid-scan SHALL discard all buffered rows; the next start SHALL begin at (0,0) with count=0.

Verification
REQ-029 activated tied 1, row_ready=1, start pulse -> 16 rows of 0xFFFF, idx 0..15 in order, count=256, single done pulse, busy low after.
REQ-030 activated = (pos_x==pos_y), row_ready=1 -> row n = 1<<n, count=16.
REQ-031 activated tied 0 -> 16 rows of 0x0000, count=0, done pulses once.
REQ-032 row_ready=0 throughout, FIFO_DEPTH=4 -> rows 0..3 buffered, scanner frozen at pos_x=15, pos_y=4, busy=1, count unchanged; ready raised -> rows 0..15 delivered in order, no row lost or duplicated.
REQ-033 start re-pulsed during SCAN and DRAIN -> ignored; count and row sequence identical to REQ-029.
REQ-034 rst asserted at pos_y=7 with rows pending -> all outputs 0 immediately; new start yields a complete, correct 16-row scan.

Source files
------------

// File: rtl/grid_scanner.sv
// ---------------------------------------------------------------------------
// grid_scanner
//
// Walks a 16x16 grid one point per clock. At each point it asks an external
// circle-membership stage whether (pos_x, pos_y) is "activated". Each row's
// answers are packed into a 16-bit bitmap. The completed rows are queued in a
// small FIFO and handed to a downstream consumer with a valid/ready handshake.
// If the FIFO is full when a row is about to complete, the scan stalls until
// the consumer frees a slot, so no row is ever lost.
//
// Ports
//   clk        single clock, all state changes on its rising edge
//   rst        asynchronous active-high reset
//   start      one-cycle request to begin a scan (honoured only in IDLE)
//   pos_x      current column, feeds the membership stage
//   pos_y      current row, feeds the membership stage
//   activated  combinational membership result for (pos_x, pos_y)
//   row_data   bitmap of the FIFO head row, bit k = point at column k
//   row_idx    row number of the FIFO head row
//   row_valid  FIFO head holds a row
//   row_ready  consumer accepts the head row this cycle
//   count      number of activated points in the current/last scan
//   busy       high whenever the scanner is not idle
//   done       one-cycle pulse when a scan has been fully delivered
// ---------------------------------------------------------------------------
module grid_scanner #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [3:0]  pos_x,
    output logic [3:0]  pos_y,
    input  logic        activated,
    output logic [15:0] row_data,
    output logic [3:0]  row_idx,
    output logic        row_valid,
    input  logic        row_ready,
    output logic [8:0]  count,
    output logic        busy,
    output logic        done
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int OCC_W = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DRAIN,
        DONE
    } state_t;

    state_t state;

    // FIFO entries are {row index, row bitmap}
    logic [19:0]      fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [OCC_W-1:0] occupancy;
    logic [OCC_W-1:0] occupancy_next;
    logic             full;

    logic [15:0] row_bits;
    logic [15:0] row_next;
    logic        sample;
    logic        push;
    logic        pop;

    // The full flag is a register, so a pop in the same cycle cannot open a
    // slot for a push: a row completing against a full FIFO always waits.
    always_comb begin
        sample = (state == SCAN) && !((pos_x == 4'd15) && full);
        push   = sample && (pos_x == 4'd15);
        pop    = row_valid && row_ready;

        row_next        = row_bits;
        row_next[pos_x] = activated;

        occupancy_next = occupancy;
        case ({push, pop})
            2'b10:   occupancy_next = occupancy + OCC_W'(1);
            2'b01:   occupancy_next = occupancy - OCC_W'(1);
            default: occupancy_next = occupancy;
        endcase
    end

    assign row_valid = (occupancy != '0);
    assign row_data  = row_valid ? fifo_mem[rd_ptr][15:0]  : 16'd0;
    assign row_idx   = row_valid ? fifo_mem[rd_ptr][19:16] : 4'd0;

    // Storage is not reset; the head is gated by row_valid so stale contents
    // never reach the outputs.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {pos_y, row_next};
        end
    end

    // Pointers wrap naturally because FIFO_DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
            full      <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            occupancy <= occupancy_next;
            full      <= (occupancy_next == OCC_W'(FIFO_DEPTH));
        end
    end

    // Scan sequencing. Completing column 15 of row 15 naturally wraps both
    // coordinates back to 0 on the way into DRAIN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            pos_x    <= 4'd0;
            pos_y    <= 4'd0;
            row_bits <= 16'd0;
            count    <= 9'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= SCAN;
                        pos_x    <= 4'd0;
                        pos_y    <= 4'd0;
                        row_bits <= 16'd0;
                        count    <= 9'd0;
                        busy     <= 1'b1;
                    end
                end
                SCAN: begin
                    if (sample) begin
                        count <= count + 9'(activated);
                        pos_x <= pos_x + 4'd1;
                        if (pos_x == 4'd15) begin
                            row_bits <= 16'd0;
                            pos_y    <= pos_y + 4'd1;
                            if (pos_y == 4'd15) begin
                                state <= DRAIN;
                            end
                        end else begin
                            row_bits <= row_next;
                        end
                    end
                end
                DRAIN: begin
                    if (occupancy == '0) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
